// File: rtl/buffer_reader.sv
// Read-side drain engine for the circular capture buffer: fetches words in order and
// presents them on a valid/ready stream. Optional overrun flag under BUFFER_READER_OVERRUN_EN.
module buffer_reader #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] write_addr,
  output logic [AW-1:0] read_addr,
  input  logic [DW-1:0] read_data,
  input  logic          flush,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          empty,
  output logic [AW-1:0] level
`ifdef BUFFER_READER_OVERRUN_EN
  ,
  input  logic          write_strobe,
  output logic          overrun,
  input  logic          clear_overrun
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] data_q, data_d;
  logic          vld_q, vld_d;

  assign read_addr = rd_q;
  assign out_data  = data_q;
  assign out_valid = vld_q;
  assign empty     = (rd_q == write_addr);
  assign level     = write_addr - rd_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  // Flush overrides everything, including an accept in the same cycle.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    data_d  = data_q;
    vld_d   = vld_q;
    if (flush) begin
      rd_d    = write_addr;
      vld_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) state_d = FETCH;
        end
        FETCH: begin
          data_d  = read_data;
          vld_d   = 1'b1;
          state_d = PRESENT;
        end
        PRESENT: begin
          if (vld_q && out_ready) begin
            rd_d    = rd_q + AW'(1);
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef BUFFER_READER_OVERRUN_EN
  logic ovr_q, ovr_d;
  logic [AW-1:0] wr_next;

  assign wr_next = write_addr + AW'(1);
  assign overrun = ovr_q;

  // A write landing on the last free entry would make the ring look empty.
  always_comb begin
    ovr_d = ovr_q;
    if (clear_overrun) ovr_d = 1'b0;
    if (write_strobe && (wr_next == rd_q)) ovr_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ovr_q <= 1'b0;
    else          ovr_q <= ovr_d;
  end
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Directed, table-driven bench for buffer_reader (AW=4, DW=8) with a behavioural buffer memory.
module tb_buffer_reader;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] write_addr;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          empty;
  logic [AW-1:0] level;
`ifdef BUFFER_READER_OVERRUN_EN
  logic          write_strobe;
  logic          overrun;
  logic          clear_overrun;
`endif

  logic [DW-1:0] mem [16];
  assign read_data = mem[read_addr];

  always #5 clock = ~clock;

  buffer_reader #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset_n(reset_n), .write_addr(write_addr), .read_addr(read_addr),
    .read_data(read_data), .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .empty(empty), .level(level)
`ifdef BUFFER_READER_OVERRUN_EN
    , .write_strobe(write_strobe), .overrun(overrun), .clear_overrun(clear_overrun)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for a presented word and checks it; the caller advances the accept edge.
  task automatic wait_word(input string nm, input int exp);
    int n = 0;
    while (!out_valid && n < 6) begin
      step();
      n++;
    end
    chk({nm, "_valid"}, int'(out_valid), 1);
    chk({nm, "_data"}, int'(out_data), exp);
  endtask

  typedef struct {
    logic [AW-1:0] wa;
    logic          rdy;
    logic [AW-1:0] e_rd;
    logic          e_vld;
    logic [DW-1:0] e_dat;
    logic          e_emp;
    logic [AW-1:0] e_lvl;
  } vec_t;

  vec_t tv [13];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4;
    mem[4] = 8'h5A; mem[15] = 8'hE5; mem[9] = 8'h99;

    tv[0]  = '{4'd4, 1'b1, 4'd0, 1'b0, 8'h00, 1'b0, 4'd4};
    tv[1]  = '{4'd4, 1'b1, 4'd0, 1'b1, 8'hA1, 1'b0, 4'd4};
    tv[2]  = '{4'd4, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 4'd3};
    tv[3]  = '{4'd4, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 4'd3};
    tv[4]  = '{4'd4, 1'b1, 4'd1, 1'b1, 8'hB2, 1'b0, 4'd3};
    tv[5]  = '{4'd4, 1'b1, 4'd2, 1'b0, 8'h00, 1'b0, 4'd2};
    tv[6]  = '{4'd4, 1'b1, 4'd2, 1'b0, 8'h00, 1'b0, 4'd2};
    tv[7]  = '{4'd4, 1'b1, 4'd2, 1'b1, 8'hC3, 1'b0, 4'd2};
    tv[8]  = '{4'd4, 1'b1, 4'd3, 1'b0, 8'h00, 1'b0, 4'd1};
    tv[9]  = '{4'd4, 1'b1, 4'd3, 1'b0, 8'h00, 1'b0, 4'd1};
    tv[10] = '{4'd4, 1'b1, 4'd3, 1'b1, 8'hD4, 1'b0, 4'd1};
    tv[11] = '{4'd4, 1'b1, 4'd4, 1'b0, 8'h00, 1'b1, 4'd0};
    tv[12] = '{4'd4, 1'b1, 4'd4, 1'b0, 8'h00, 1'b1, 4'd0};

    reset_n = 1'b0; write_addr = '0; flush = 1'b0; out_ready = 1'b0;
`ifdef BUFFER_READER_OVERRUN_EN
    write_strobe = 1'b0; clear_overrun = 1'b0;
`endif
    #2;
    chk("rst_read_addr", int'(read_addr), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_level", int'(level), 0);
    #1 reset_n = 1'b1;

    // In-order stream of four words with ready held high
    for (int i = 0; i < 13; i++) begin
      write_addr = tv[i].wa;
      out_ready  = tv[i].rdy;
      step();
      chk($sformatf("stream%0d_rd", i), int'(read_addr), int'(tv[i].e_rd));
      chk($sformatf("stream%0d_vld", i), int'(out_valid), int'(tv[i].e_vld));
      if (tv[i].e_vld) chk($sformatf("stream%0d_dat", i), int'(out_data), int'(tv[i].e_dat));
      chk($sformatf("stream%0d_emp", i), int'(empty), int'(tv[i].e_emp));
      chk($sformatf("stream%0d_lvl", i), int'(level), int'(tv[i].e_lvl));
    end

    // Backpressure: word held stable for 10 stalled cycles, then one accept
    write_addr = 4'd5; out_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 8'h5A);
      chk("bp_rd", int'(read_addr), 4);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_accept_rd", int'(read_addr), 5);
    chk("bp_accept_vld", int'(out_valid), 0);
    step(); step();
    chk("bp_idle_rd", int'(read_addr), 5);
    chk("bp_idle_vld", int'(out_valid), 0);

    // Wrap: read_addr 15, write_addr 1
    write_addr = 4'd15; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("wrap_flush_rd", int'(read_addr), 15);
    write_addr = 4'd1;
    #1;
    chk("wrap_level", int'(level), 2);
    wait_word("wrap_w15", 8'hE5);
    step();
    chk("wrap_rd0", int'(read_addr), 0);
    wait_word("wrap_w0", 8'hA1);
    step();
    chk("wrap_rd1", int'(read_addr), 1);
    chk("wrap_empty", int'(empty), 1);

    // Flush in PRESENT beats a simultaneous accept
    out_ready = 1'b0; write_addr = 4'd3; flush = 1'b1;
    step();
    flush = 1'b0; write_addr = 4'd9;
    step(); step();
    chk("flush_pre_vld", int'(out_valid), 1);
    chk("flush_pre_dat", int'(out_data), 8'hD4);
    flush = 1'b1; out_ready = 1'b1;
    step();
    chk("flush_rd", int'(read_addr), 9);
    chk("flush_vld", int'(out_valid), 0);
    flush = 1'b0; out_ready = 1'b0;
    step();
    chk("flush_after_rd", int'(read_addr), 9);
    chk("flush_after_vld", int'(out_valid), 0);
    chk("flush_after_emp", int'(empty), 1);

    // Asynchronous reset mid-PRESENT
    write_addr = 4'd5;
    step(); step();
    chk("rstmid_pre_vld", int'(out_valid), 1);
    chk("rstmid_pre_dat", int'(out_data), 8'h99);
    #3 reset_n = 1'b0;
    #1;
    chk("rstmid_rd", int'(read_addr), 0);
    chk("rstmid_vld", int'(out_valid), 0);
    chk("rstmid_dat", int'(out_data), 0);
    #2 reset_n = 1'b1;
    step();
    chk("rstrel_c1_vld", int'(out_valid), 0);
    step();
    chk("rstrel_c2_vld", int'(out_valid), 1);
    chk("rstrel_c2_dat", int'(out_data), 8'hA1);
    chk("rstrel_c2_rd", int'(read_addr), 0);

`ifdef BUFFER_READER_OVERRUN_EN
    chk("ovr_reset", int'(overrun), 0);
    write_addr = 4'd15; write_strobe = 1'b1;
    step();
    chk("ovr_set", int'(overrun), 1);
    write_strobe = 1'b0; clear_overrun = 1'b1;
    step();
    chk("ovr_clear", int'(overrun), 0);
    clear_overrun = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
